// File: rtl/mem_access_unit.sv
// mem_access_unit
// Bridges the multicycle controller's MEM_read / MEM_write level strobes onto
// a req/ack memory bus. It captures read data for the IR/TR/DI load paths and
// stalls the controller through mem_busy while an access is in flight.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a WAIT-state watchdog aborts an access after TO_LIMIT cycles
//   without m_ack. The abort sets mem_err and, for reads, returns rdata = 0
//   with a rd_valid pulse.
//   When undefined, WAIT holds until m_ack arrives.
//
// Ports
//   clk        in   rising-edge system clock
//   rst        in   asynchronous active-low reset
//   MEM_read   in   read strobe (sampled in IDLE)
//   MEM_write  in   write strobe (sampled in IDLE)
//   addr       in   [ADDR_W] muxed PC/TR address
//   wdata      in   [DATA_W] store data
//   rdata      out  [DATA_W] captured read data
//   rd_valid   out  one-cycle pulse when rdata was just updated
//   mem_busy   out  controller stall
//   mem_err    out  sticky error flag, cleared only by reset
//   m_req      out  bus request, one cycle per access
//   m_we       out  bus write enable
//   m_addr     out  [ADDR_W] registered bus address
//   m_wdata    out  [DATA_W] registered bus write data
//   m_rdata    in   [DATA_W] bus read data, valid with m_ack
//   m_ack      in   bus acknowledge pulse
module mem_access_unit #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int TO_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_read,
  input  logic              MEM_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              mem_busy,
  output logic              mem_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t state, next_state;
  logic   accept;
  logic   conflict;
  logic   timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TO_LIMIT + 1) > 4) ? $clog2(TO_LIMIT + 1) : 4;
  logic [CNT_W-1:0] to_cnt;

  // The counter value equals the number of WAIT cycles already spent, so the
  // TO_LIMIT-th WAIT cycle without an ack is the one that aborts.
  assign timeout_hit = (state == S_WAIT) && !m_ack &&
                       (to_cnt == CNT_W'(TO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (accept)
      to_cnt <= '0;
    else if (state == S_WAIT)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // m_req and rd_valid decode straight from state, so an asynchronous reset
  // drops them immediately without waiting for a clock edge.
  always_comb begin
    next_state = state;
    mem_busy   = 1'b0;
    m_req      = 1'b0;
    rd_valid   = 1'b0;
    accept     = 1'b0;
    conflict   = 1'b0;
    case (state)
      S_IDLE: begin
        if (MEM_read && MEM_write) begin
          conflict = 1'b1;
        end else if (MEM_read || MEM_write) begin
          accept     = 1'b1;
          mem_busy   = 1'b1;
          next_state = S_REQ;
        end
      end
      S_REQ: begin
        m_req      = 1'b1;
        mem_busy   = 1'b1;
        next_state = m_ack ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        mem_busy = 1'b1;
        if (m_ack || timeout_hit)
          next_state = S_DONE;
      end
      S_DONE: begin
        rd_valid   = !m_we;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Bus-side registers and read capture. m_we stays latched after the access
  // so that DONE can tell a read from a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_addr  <= '0;
      m_wdata <= '0;
      m_we    <= 1'b0;
      rdata   <= '0;
      mem_err <= 1'b0;
    end else begin
      if (accept) begin
        m_addr  <= addr;
        m_wdata <= wdata;
        m_we    <= MEM_write;
      end
      if (conflict)
        mem_err <= 1'b1;
      if ((state == S_REQ || state == S_WAIT) && m_ack && !m_we)
        rdata <= m_rdata;
      if (timeout_hit) begin
        mem_err <= 1'b1;
        if (!m_we)
          rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: read, write, strobe conflict,
// early ack, stray ack, mid-transaction reset and (with MEM_TIMEOUT_EN) the
// WAIT watchdog.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_read, MEM_write;
  logic [12:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rd_valid, mem_busy, mem_err, m_req, m_we;
  logic [12:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic        m_ack;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_W(13), .DATA_W(8), .TO_LIMIT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .MEM_read (MEM_read),
    .MEM_write(MEM_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .mem_busy (mem_busy),
    .mem_err  (mem_err),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [12:0] a, input logic [7:0] wd,
                               input logic ack, input logic [7:0] rdat);
    MEM_read  = rd;
    MEM_write = wr;
    addr      = a;
    wdata     = wd;
    m_ack     = ack;
    m_rdata   = rdat;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 13'h0, 8'h0, 0, 8'h0);
    #12;
    checkOutput("rst_rdata",  32'(rdata), 32'h0);
    checkOutput("rst_rdv",    32'(rd_valid), 32'h0);
    checkOutput("rst_busy",   32'(mem_busy), 32'h0);
    checkOutput("rst_err",    32'(mem_err), 32'h0);
    checkOutput("rst_req",    32'(m_req), 32'h0);
    checkOutput("rst_we",     32'(m_we), 32'h0);
    checkOutput("rst_maddr",  32'(m_addr), 32'h0);
    checkOutput("rst_mwdata", 32'(m_wdata), 32'h0);
    step();
    rst = 1'b1;

    // Read 0x0A5, ack during WAIT with 0x3C.
    step();
    applyStimulus(1, 0, 13'h0A5, 8'h00, 0, 8'h00);
    checkOutput("rd_strobe_busy", 32'(mem_busy), 32'h1);
    checkOutput("rd_strobe_req",  32'(m_req), 32'h0);
    step();
    applyStimulus(0, 0, 13'h0A5, 8'h00, 0, 8'h00);
    checkOutput("rd_req",       32'(m_req), 32'h1);
    checkOutput("rd_req_busy",  32'(mem_busy), 32'h1);
    checkOutput("rd_req_addr",  32'(m_addr), 32'h0A5);
    checkOutput("rd_req_we",    32'(m_we), 32'h0);
    step();
    applyStimulus(0, 0, 13'h0A5, 8'h00, 1, 8'h3C);
    checkOutput("rd_wait_req",  32'(m_req), 32'h0);
    checkOutput("rd_wait_busy", 32'(mem_busy), 32'h1);
    checkOutput("rd_wait_rdv",  32'(rd_valid), 32'h0);
    step();
    applyStimulus(0, 0, 13'h0A5, 8'h00, 0, 8'h00);
    checkOutput("rd_done_rdv",   32'(rd_valid), 32'h1);
    checkOutput("rd_done_busy",  32'(mem_busy), 32'h0);
    checkOutput("rd_done_rdata", 32'(rdata), 32'h3C);
    step();
    checkOutput("rd_idle_rdv",   32'(rd_valid), 32'h0);
    checkOutput("rd_idle_rdata", 32'(rdata), 32'h3C);

    // Write 0x81 to 0x1FF, ack in the REQ cycle.
    applyStimulus(0, 1, 13'h1FF, 8'h81, 0, 8'h00);
    checkOutput("wr_strobe_busy", 32'(mem_busy), 32'h1);
    step();
    applyStimulus(0, 0, 13'h1FF, 8'h81, 1, 8'hEE);
    checkOutput("wr_req",    32'(m_req), 32'h1);
    checkOutput("wr_we",     32'(m_we), 32'h1);
    checkOutput("wr_maddr",  32'(m_addr), 32'h1FF);
    checkOutput("wr_mwdata", 32'(m_wdata), 32'h81);
    step();
    applyStimulus(0, 0, 13'h1FF, 8'h81, 0, 8'h00);
    checkOutput("wr_done_rdv",   32'(rd_valid), 32'h0);
    checkOutput("wr_done_busy",  32'(mem_busy), 32'h0);
    checkOutput("wr_done_rdata", 32'(rdata), 32'h3C);
    step();
    checkOutput("wr_idle_req", 32'(m_req), 32'h0);

    // Both strobes at once: no access, sticky error.
    applyStimulus(1, 1, 13'h123, 8'h55, 0, 8'h00);
    checkOutput("both_err_before", 32'(mem_err), 32'h0);
    step();
    applyStimulus(0, 0, 13'h123, 8'h55, 0, 8'h00);
    checkOutput("both_req",   32'(m_req), 32'h0);
    checkOutput("both_err",   32'(mem_err), 32'h1);
    checkOutput("both_busy",  32'(mem_busy), 32'h0);
    checkOutput("both_maddr", 32'(m_addr), 32'h1FF);

    // Stray ack in IDLE changes nothing.
    applyStimulus(0, 0, 13'h123, 8'h55, 1, 8'h99);
    step();
    applyStimulus(0, 0, 13'h123, 8'h55, 0, 8'h00);
    checkOutput("stray_req",   32'(m_req), 32'h0);
    checkOutput("stray_busy",  32'(mem_busy), 32'h0);
    checkOutput("stray_rdv",   32'(rd_valid), 32'h0);
    checkOutput("stray_rdata", 32'(rdata), 32'h3C);

    // Minimum latency read: ack in REQ, rd_valid two cycles after strobe.
    applyStimulus(1, 0, 13'h055, 8'h00, 0, 8'h00);
    step();
    applyStimulus(0, 0, 13'h055, 8'h00, 1, 8'h5A);
    checkOutput("fast_req", 32'(m_req), 32'h1);
    step();
    applyStimulus(0, 0, 13'h055, 8'h00, 0, 8'h00);
    checkOutput("fast_rdv",   32'(rd_valid), 32'h1);
    checkOutput("fast_rdata", 32'(rdata), 32'h5A);
    checkOutput("fast_err",   32'(mem_err), 32'h1);
    step();

    // Reset while waiting for ack.
    applyStimulus(1, 0, 13'h100, 8'h00, 0, 8'h00);
    step();
    applyStimulus(0, 0, 13'h100, 8'h00, 0, 8'h00);
    step();
    checkOutput("mid_wait_busy", 32'(mem_busy), 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_req",   32'(m_req), 32'h0);
    checkOutput("mid_rst_busy",  32'(mem_busy), 32'h0);
    checkOutput("mid_rst_rdata", 32'(rdata), 32'h0);
    checkOutput("mid_rst_err",   32'(mem_err), 32'h0);
    checkOutput("mid_rst_maddr", 32'(m_addr), 32'h0);
    step();
    rst = 1'b1;
    step();

    // Post-reset read completes normally.
    applyStimulus(1, 0, 13'h0AA, 8'h00, 0, 8'h00);
    step();
    applyStimulus(0, 0, 13'h0AA, 8'h00, 0, 8'h00);
    checkOutput("post_req",   32'(m_req), 32'h1);
    checkOutput("post_maddr", 32'(m_addr), 32'h0AA);
    step();
    applyStimulus(0, 0, 13'h0AA, 8'h00, 1, 8'hC3);
    step();
    applyStimulus(0, 0, 13'h0AA, 8'h00, 0, 8'h00);
    checkOutput("post_rdv",   32'(rd_valid), 32'h1);
    checkOutput("post_rdata", 32'(rdata), 32'hC3);
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: 15 WAIT cycles, then an aborting DONE.
    applyStimulus(1, 0, 13'h0F0, 8'h00, 0, 8'h00);
    step();
    applyStimulus(0, 0, 13'h0F0, 8'h00, 0, 8'h00);
    checkOutput("to_req", 32'(m_req), 32'h1);
    for (int i = 0; i < 15; i++) begin
      step();
      checkOutput("to_wait_busy", 32'(mem_busy), 32'h1);
      checkOutput("to_wait_rdv",  32'(rd_valid), 32'h0);
    end
    checkOutput("to_err_before", 32'(mem_err), 32'h0);
    step();
    checkOutput("to_done_rdv",   32'(rd_valid), 32'h1);
    checkOutput("to_done_rdata", 32'(rdata), 32'h0);
    checkOutput("to_done_err",   32'(mem_err), 32'h1);
    checkOutput("to_done_busy",  32'(mem_busy), 32'h0);
    step();
    checkOutput("to_idle_rdv",  32'(rd_valid), 32'h0);
    checkOutput("to_idle_busy", 32'(mem_busy), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
